// File: rtl/disp_pkg.sv
// Shared constants and helpers for the seven-segment display path.
package disp_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned MAX_DIG = 32;

    localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;
    localparam logic             DP_OFF     = 1'b1;

    // All-anodes-off vector: low n bits set, caller truncates to its digit count.
    function automatic logic [MAX_DIG-1:0] an_off(input int unsigned n);
        logic [MAX_DIG-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_DIG; i++) begin
            if (i < n) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler; tick is high during the cycle the count sits at DIV-1.
module tick_gen #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Next count with wrap at DIV-1.
    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
        end
    end

    // Count register; tick is registered from the next count so it lines up with cnt == DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= (CNT_LAST == '0);
        end else begin
            cnt  <= cnt_nxt;
            tick <= (cnt_nxt == CNT_LAST);
        end
    end

endmodule

// File: rtl/disp_scan_mux.sv
// Scans NDIG snapshotted BCD digits onto one shared digit bus with active-low anodes.
module disp_scan_mux
    import disp_pkg::*;
#(
    parameter int unsigned NDIG = 4,
    parameter int unsigned DIV  = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BCD_W*NDIG-1:0]   digits_in,
    input  logic [NDIG-1:0]         dp_in,
    input  logic                    lz_en,
    input  logic                    enable,
    output logic [BCD_W-1:0]        digit_out,
    output logic                    dp_out,
    output logic [NDIG-1:0]         an_out,
    output logic                    frame_start
);

    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned DW    = BCD_W * NDIG;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
    localparam logic [NDIG-1:0]  AN_OFF   = NDIG'(an_off(NDIG));

    logic                  tick;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic                  new_frame;
    logic [DW-1:0]         snap_digits;
    logic [NDIG-1:0]       snap_dp;
    logic [NDIG-1:0]       snap_blank;
    logic [NDIG-1:0]       blank_live;
    logic [BCD_W-1:0]      sel_digit;
    logic                  sel_dp;
    logic                  sel_blank;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Slot index to be entered on the next tick edge.
    always_comb begin
        idx_nxt = idx + IDX_W'(1);
        if (idx == IDX_LAST) begin
            idx_nxt = '0;
        end
        new_frame = (idx_nxt == '0);
    end

    // Leading-zero blank vector from the live inputs, latched only at frame capture.
    always_comb begin
        logic zero_run;
        blank_live = '0;
        zero_run   = 1'b1;
        for (int i = int'(NDIG) - 1; i >= 1; i--) begin
            zero_run      = zero_run && (digits_in[BCD_W*i +: BCD_W] == '0) && !dp_in[i];
            blank_live[i] = lz_en && zero_run;
        end
    end

    // Digit source for the slot being entered; digit 0 bypasses the snapshot with the values being captured.
    always_comb begin
        sel_digit = snap_digits[{idx_nxt, 2'b00} +: BCD_W];
        sel_dp    = snap_dp[idx_nxt];
        sel_blank = snap_blank[idx_nxt];
        if (new_frame) begin
            sel_digit = digits_in[BCD_W-1:0];
            sel_dp    = dp_in[0];
            sel_blank = 1'b0;
        end
    end

    // Index, frame snapshot and output registers, all advancing together on the tick edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= IDX_LAST;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            an_out      <= AN_OFF;
            digit_out   <= BLANK_CODE;
            dp_out      <= DP_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && new_frame;
            if (tick) begin
                idx <= idx_nxt;
                if (new_frame) begin
                    snap_digits <= digits_in;
                    snap_dp     <= dp_in;
                    snap_blank  <= blank_live;
                end
                if (!enable || sel_blank) begin
                    an_out    <= AN_OFF;
                    digit_out <= BLANK_CODE;
                    dp_out    <= DP_OFF;
                end else begin
                    an_out    <= AN_OFF & ~(NDIG'(1) << idx_nxt);
                    digit_out <= sel_digit;
                    dp_out    <= ~sel_dp;
                end
            end
        end
    end

endmodule

// File: doc/disp_scan_mux.md
Name: disp_scan_mux

Overview:
- Time-multiplexes NDIG BCD digits onto one shared 4-bit digit bus that feeds the seven-segment decoder.
- Drives the active-low common-anode enables and the decimal-point line.
- Sits directly upstream of the decoder, between the counter/score logic producing packed BCD and the board display pins.
- Snapshots the input once per frame so a frame never shows a torn value.

Parameters:
- NDIG, 4, number of multiplexed digits (>=2); digit NDIG-1 is most significant.
- DIV, 50000, clock cycles per digit slot (>=1); 50 MHz clock gives 1 kHz slot rate.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- digits_in  input  4*NDIG  packed BCD; digit i = bits [4i+3:4i].
- dp_in  input  NDIG  decimal point request per digit, active-high.
- lz_en  input  1  leading-zero blanking enable.
- enable  input  1  display on; 0 blanks all anodes.
- digit_out  output  4  code to decoder; 4'hF = blank.
- dp_out  output  1  decimal point, active-low.
- an_out  output  NDIG  anode enables, active-low, one-hot-low when lit.
- frame_start  output  1  one-cycle pulse when digit 0 slot begins.

Behaviour:
- Reset: async, active-high, effective immediately including mid-scan.
  - Prescaler = 0, idx = NDIG-1, snapshot = 0.
  - an_out = all ones, digit_out = 4'hF, dp_out = 1, frame_start = 0.
- Prescaler: counts 0..DIV-1 and wraps. The "tick cycle" is the cycle with prescaler == DIV-1. DIV=1 ticks every cycle. Width is clog2(DIV), minimum 1.
- Index: on the tick edge, idx <= (idx==NDIG-1) ? 0 : idx+1. First tick after reset selects digit 0.
- Snapshot:
  - On a tick edge where next idx is 0, snapshot <= digits_in, dp_in and lz_en, all captured in that edge.
  - The digit 0 slot uses the freshly captured values (bypass the live input into the output path).
  - Input changes at any other time are invisible until the next frame.
- frame_start: 1 for exactly the cycle following the tick edge that entered digit 0; 0 otherwise.
- Outputs: registered. They update only on tick edges (and on reset), all on the same edge as idx, so there is zero cycle skew between an_out and digit_out.
  - Lit slot: an_out bit idx = 0, others 1; digit_out = snapshot digit idx; dp_out = ~snapshot dp idx.
  - Codes 10-15 pass through unchanged; the decoder blanks them.
- Leading-zero blanking: applies when snapshot lz_en = 1. Digit i (i>0) is blanked when, for every j in i..NDIG-1, digit j == 0 and dp j == 0.
  - Blanked slot: an_out all ones, digit_out 4'hF, dp_out 1.
  - Digit 0 is never blanked.
  - Compute the blank vector once per snapshot.
- enable = 0: prescaler, idx, snapshot and frame_start keep running. At the next tick edge, outputs take the blank values. Re-enabling resumes at the next tick edge with the current idx.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package `disp_pkg`: BLANK_CODE = 4'hF, DP_OFF = 1'b1, function for the all-ones anode-off vector of width NDIG.
- Sub-module `tick_gen` (parameter DIV; ports clk, rst, tick): prescaler only, reused by other timed display blocks.
- Remaining logic (index, snapshot, blank vector, output registers) stays in disp_scan_mux.

Test Plan (NDIG=4, DIV=4 unless noted):
1. Assert rst mid-run -> same cycle an_out=4'b1111, digit_out=4'hF, dp_out=1, frame_start=0. After release, first tick edge comes 4 cycles later.
2. digits_in=16'h1234, dp_in=4'b0100, lz_en=0, enable=1 -> slot sequence (an_out/digit_out/dp_out):
   - 1110/4/1
   - 1101/3/1
   - 1011/2/0
   - 0111/1/1
   - Each slot holds 4 cycles, then the sequence wraps. frame_start pulses once every 16 cycles, aligned to the 1110 slot.
3. Start at 16'h1234, change digits_in to 16'h9876 during the digit-2 slot -> the remaining slots still show 2 then 1. The next frame shows 6,7,8,9.
4. lz_en=1 with the following inputs:
   - 16'h0050 -> digits 3 and 2 blanked (an_out=1111, digit_out=F); digit 1=5; digit 0=0.
   - 16'h0000 -> only digit 0 is lit, showing 0.
   - 16'h0000 with dp_in=4'b0100 -> digit 3 blanked; digit 2 shows 0 with dp_out=0.
5. Drop enable=0 mid-frame -> an_out=1111 from the next tick edge onward, while frame_start keeps a 16-cycle period. Raise enable=1 -> lights resume at the next tick edge with the correct idx.
6. DIV=1, NDIG=2, digits 8'h59 -> an_out alternates 10/01 every cycle with digit_out 9/5. frame_start pulses every 2 cycles.
